// File: rtl/chip8_ram_arbiter.sv
// Two-requester arbiter for the single port of the 4096x8 chip8 RAM (req/ack handshake).
// Define CHIP8_ARB_RR_EN for round-robin arbitration; otherwise requester A has fixed priority.
module chip8_ram_arbiter (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [11:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [11:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic [11:0] ram_address,
  output logic [7:0]  ram_data,
  output logic        ram_wren,
  input  logic [7:0]  ram_q
);

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {IDLE, ACK_A, ACK_B} state_t;

  state_t              state_p0, state_nxt;
  logic                grant_a, grant_b;
  logic [ADDR_W-1:0]   addr_hold_p0;
  logic [DATA_W-1:0]   data_hold_p0;

`ifdef CHIP8_ARB_RR_EN
  logic                last_b_p0;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)
      last_b_p0 <= 1'b1;
    else if (grant_a || grant_b)
      last_b_p0 <= grant_b;
  end
`endif

  // Grants only happen in IDLE; reset gates them so the RAM bus shows its reset values at once.
  always_comb begin
    state_nxt = state_p0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state_p0)
      IDLE: begin
        if (!reset) begin
`ifdef CHIP8_ARB_RR_EN
          grant_a = a_req && (!b_req || last_b_p0);
`else
          grant_a = a_req;
`endif
          grant_b = b_req && !grant_a;
        end
        if (grant_a)
          state_nxt = ACK_A;
        else if (grant_b)
          state_nxt = ACK_B;
      end
      ACK_A:   state_nxt = IDLE;
      ACK_B:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_wren    = 1'b0;
    ram_address = addr_hold_p0;
    ram_data    = data_hold_p0;
    if (grant_a) begin
      ram_wren    = a_we;
      ram_address = a_addr;
      ram_data    = a_wdata;
    end else if (grant_b) begin
      ram_wren    = b_we;
      ram_address = b_addr;
      ram_data    = b_wdata;
    end
  end

  assign a_ack   = (state_p0 == ACK_A);
  assign b_ack   = (state_p0 == ACK_B);
  assign a_rdata = a_ack ? ram_q : '0;
  assign b_rdata = b_ack ? ram_q : '0;

  // Stage p0: state plus the last driven address/data, held while no grant is active.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_p0     <= IDLE;
      addr_hold_p0 <= '0;
      data_hold_p0 <= '0;
    end else begin
      state_p0 <= state_nxt;
      if (grant_a || grant_b) begin
        addr_hold_p0 <= ram_address;
        data_hold_p0 <= ram_data;
      end
    end
  end

endmodule

// File: tb/tb_chip8_ram_arbiter.sv
// Self-checking bench for chip8_ram_arbiter: behavioural RAM, reference memory and arbitration model.
module tb_chip8_ram_arbiter;

`ifdef CHIP8_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [11:0] a_addr = '0;
  logic [7:0]  a_wdata = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [11:0] b_addr = '0;
  logic [7:0]  b_wdata = '0;
  logic        a_ack, b_ack, ram_wren;
  logic [7:0]  a_rdata, b_rdata, ram_data, ram_q;
  logic [11:0] ram_address;

  logic [7:0]  mem [4096];
  logic [7:0]  ref_mem [4096];
  bit          ref_valid [4096];
  logic [11:0] pool [16];
  bit          mdl_last_b = 1'b1;
  int          n_cmp = 0;
  int          n_err = 0;

  chip8_ram_arbiter dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Synchronous single-port RAM: address captured on the edge, q valid the following cycle.
  always @(posedge CLOCK_50) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic access(input bit is_b, input bit we, input logic [11:0] addr,
                        input logic [7:0] wd, output logic [7:0] rd,
                        output int lat, output bit other);
    bit found;
    found = 1'b0; lat = 0; other = 1'b0; rd = '0;
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    while (!found && lat < 10) begin
      @(negedge CLOCK_50); #1;
      lat++;
      if (is_b ? a_ack : b_ack) other = 1'b1;
      if (is_b ? b_ack : a_ack) begin
        found = 1'b1;
        rd = is_b ? b_rdata : a_rdata;
      end
    end
    if (is_b) b_req = 1'b0; else a_req = 1'b0;
    if (!found) lat = 99;
    else begin
      if (we) begin ref_mem[addr] = wd; ref_valid[addr] = 1'b1; end
      mdl_last_b = is_b;
    end
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++;
    if ({a_ack, b_ack, a_rdata, b_rdata, ram_wren, ram_address, ram_data} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got ack=%b%b rd=%h/%h wren=%b addr=%h data=%h required all zero",
               a_ack, b_ack, a_rdata, b_rdata, ram_wren, ram_address, ram_data);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'h123; a_wdata = 8'h77;
    @(posedge CLOCK_50); #2;
    n_cmp++;
    if (a_ack !== 1'b1 || ram_address !== 12'h123) begin
      n_err++;
      $display("FAIL reset_pre_ack: got a_ack=%b addr=%h required 1 / 123", a_ack, ram_address);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({a_ack, b_ack, a_rdata, b_rdata, ram_wren, ram_address, ram_data} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got ack=%b%b rd=%h/%h wren=%b addr=%h data=%h required all zero",
               a_ack, b_ack, a_rdata, b_rdata, ram_wren, ram_address, ram_data);
    end
    a_req = 1'b0;
    ref_mem[12'h123] = 8'h77; ref_valid[12'h123] = 1'b1;
    mdl_last_b = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50); #1;
      n_cmp++;
      if ({ram_wren, a_ack, b_ack} !== 3'b000) begin
        n_err++;
        $display("FAIL reset_idle_quiet[%0d]: got wren/acks=%b required 000", i, {ram_wren, a_ack, b_ack});
      end
    end
    @(negedge CLOCK_50);
  endtask

  task automatic test_write_read;
    logic [7:0] rd; int lat; bit oth;
    access(1'b0, 1'b1, 12'h200, 8'h5A, rd, lat, oth);
    n_cmp++;
    if (lat !== 1 || oth !== 1'b0) begin
      n_err++;
      $display("FAIL a_write_lat: got lat=%0d b_ack_seen=%b required 1 / 0", lat, oth);
    end
    access(1'b0, 1'b0, 12'h200, 8'h00, rd, lat, oth);
    n_cmp++;
    if (lat !== 1 || oth !== 1'b0 || rd !== ref_mem[12'h200]) begin
      n_err++;
      $display("FAIL a_read_back: got lat=%0d b_ack_seen=%b rdata=%h required 1 / 0 / %h",
               lat, oth, rd, ref_mem[12'h200]);
    end
  endtask

  task automatic test_b_fresh;
    logic [7:0] rd; int lat; bit oth;
    access(1'b1, 1'b1, 12'hFFF, 8'hC3, rd, lat, oth);
    n_cmp++;
    if (lat !== 1 || oth !== 1'b0) begin
      n_err++;
      $display("FAIL b_write_lat: got lat=%0d a_ack_seen=%b required 1 / 0", lat, oth);
    end
    access(1'b1, 1'b0, 12'hFFF, 8'h00, rd, lat, oth);
    n_cmp++;
    if (lat !== 1 || rd !== 8'hC3) begin
      n_err++;
      $display("FAIL b_read_fff: got lat=%0d rdata=%h required 1 / c3", lat, rd);
    end
    access(1'b0, 1'b1, 12'h000, 8'h11, rd, lat, oth);
    access(1'b1, 1'b0, 12'h000, 8'h00, rd, lat, oth);
    n_cmp++;
    if (lat !== 1 || oth !== 1'b0 || rd !== 8'h11) begin
      n_err++;
      $display("FAIL b_read_000: got lat=%0d a_ack_seen=%b rdata=%h required 1 / 0 / 11", lat, oth, rd);
    end
  endtask

  task automatic test_back_to_back;
    int acks, since;
    bit prev;
    a_req = 1'b1; a_we = 1'($urandom_range(0, 1));
    a_addr = pool[$urandom_range(0, 15)]; a_wdata = 8'($urandom);
    acks = 0; since = 0; prev = 1'b0;
    for (int i = 0; i < 40 && acks < 6; i++) begin
      @(negedge CLOCK_50); #1;
      since++;
      n_cmp++;
      if (ram_wren && prev) begin
        n_err++;
        $display("FAIL b2b_wren_consecutive: got wren=1 twice required never");
      end
      prev = ram_wren;
      if (a_ack) begin
        n_cmp++;
        if (since !== (acks == 0 ? 1 : 2)) begin
          n_err++;
          $display("FAIL b2b_interval[%0d]: got %0d cycles required %0d", acks, since, acks == 0 ? 1 : 2);
        end
        if (a_we) begin
          ref_mem[a_addr] = a_wdata; ref_valid[a_addr] = 1'b1;
        end else if (ref_valid[a_addr]) begin
          n_cmp++;
          if (a_rdata !== ref_mem[a_addr]) begin
            n_err++;
            $display("FAIL b2b_rdata[%h]: got %h required %h", a_addr, a_rdata, ref_mem[a_addr]);
          end
        end
        since = 0; acks++; mdl_last_b = 1'b0;
        if (acks < 6) begin
          a_we = 1'($urandom_range(0, 1));
          a_addr = pool[$urandom_range(0, 15)]; a_wdata = 8'($urandom);
        end else a_req = 1'b0;
      end else begin
        n_cmp++;
        if (ram_wren !== a_we || ram_address !== a_addr || (a_we && ram_data !== a_wdata)) begin
          n_err++;
          $display("FAIL b2b_grant_bus: got wren=%b addr=%h data=%h required %b %h %h",
                   ram_wren, ram_address, ram_data, a_we, a_addr, a_wdata);
        end
      end
    end
    n_cmp++;
    if (acks != 6) begin
      n_err++;
      $display("FAIL b2b_timeout: got %0d acks required 6", acks);
    end
    a_req = 1'b0;
    @(negedge CLOCK_50);
  endtask

  task automatic test_contention;
    int acks;
    bit got_b, exp_b, found;
    a_req = 1'b1; a_we = 1'b0; a_addr = pool[$urandom_range(0, 15)];
    b_req = 1'b1; b_we = 1'b0; b_addr = pool[$urandom_range(0, 15)];
    acks = 0;
    for (int i = 0; i < 40 && acks < 8; i++) begin
      @(negedge CLOCK_50); #1;
      if (a_ack || b_ack) begin
        got_b = b_ack;
        exp_b = RR ? !mdl_last_b : 1'b0;
        n_cmp++;
        if ((a_ack && b_ack) || got_b !== exp_b) begin
          n_err++;
          $display("FAIL contention_order[%0d]: got a_ack=%b b_ack=%b required winner %s",
                   acks, a_ack, b_ack, exp_b ? "B" : "A");
        end
        if (got_b && ref_valid[b_addr]) begin
          n_cmp++;
          if (b_rdata !== ref_mem[b_addr]) begin
            n_err++;
            $display("FAIL contention_b_rdata: got %h required %h", b_rdata, ref_mem[b_addr]);
          end
        end
        if (!got_b && ref_valid[a_addr]) begin
          n_cmp++;
          if (a_rdata !== ref_mem[a_addr]) begin
            n_err++;
            $display("FAIL contention_a_rdata: got %h required %h", a_rdata, ref_mem[a_addr]);
          end
        end
        mdl_last_b = got_b; acks++;
        if (got_b) b_addr = pool[$urandom_range(0, 15)];
        else       a_addr = pool[$urandom_range(0, 15)];
      end
    end
    n_cmp++;
    if (acks != 8) begin
      n_err++;
      $display("FAIL contention_timeout: got %0d acks required 8", acks);
    end
    a_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge CLOCK_50); #1;
      if (b_ack) begin
        found = 1'b1;
        if (ref_valid[b_addr]) begin
          n_cmp++;
          if (b_rdata !== ref_mem[b_addr]) begin
            n_err++;
            $display("FAIL contention_b_late_rdata: got %h required %h", b_rdata, ref_mem[b_addr]);
          end
        end
      end
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL contention_b_after_a_drop: got no b_ack required one");
    end
    b_req = 1'b0; mdl_last_b = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset_mid;
    logic [7:0] rd, v; int lat, extra; bit oth;
    v = 8'($urandom);
    access(1'b0, 1'b1, 12'h300, v, rd, lat, oth);
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'h2AB;
    @(posedge CLOCK_50); #2;
    n_cmp++;
    if (a_ack !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre_ack: got a_ack=%b required 1", a_ack);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (a_ack !== 1'b0 || a_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset_ack: got a_ack=%b a_rdata=%h required 0 / 00", a_ack, a_rdata);
    end
    a_req = 1'b0; mdl_last_b = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    access(1'b0, 1'b0, 12'h300, 8'h00, rd, lat, oth);
    n_cmp++;
    if (lat !== 1 || rd !== v) begin
      n_err++;
      $display("FAIL mid_rerequest: got lat=%0d rdata=%h required 1 / %h", lat, rd, v);
    end
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50); #1;
      if (a_ack || b_ack) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL mid_single_ack: got %0d extra acks required 0", extra);
    end
  endtask

  task automatic test_random;
    int pend;
    bit live, gb;
    pend = 0;
    for (int it = 0; it < 400; it++) begin
      live = (it < 380);
      @(negedge CLOCK_50); #1;
      n_cmp++;
      if ({a_ack, b_ack} !== {pend == 1, pend == 2}) begin
        n_err++;
        $display("FAIL random_ack[%0d]: got a/b ack=%b%b required %b%b",
                 it, a_ack, b_ack, pend == 1, pend == 2);
      end
      if (pend == 1) begin
        if (a_we) begin
          ref_mem[a_addr] = a_wdata; ref_valid[a_addr] = 1'b1;
        end else if (ref_valid[a_addr]) begin
          n_cmp++;
          if (a_rdata !== ref_mem[a_addr]) begin
            n_err++;
            $display("FAIL random_a_rdata[%h]: got %h required %h", a_addr, a_rdata, ref_mem[a_addr]);
          end
        end
        a_req = live && ($urandom_range(0, 1) == 1);
        a_we = 1'($urandom_range(0, 1)); a_addr = pool[$urandom_range(0, 15)]; a_wdata = 8'($urandom);
      end else if (!a_req && live && $urandom_range(0, 2) == 0) begin
        a_req = 1'b1;
        a_we = 1'($urandom_range(0, 1)); a_addr = pool[$urandom_range(0, 15)]; a_wdata = 8'($urandom);
      end
      if (pend == 2) begin
        if (b_we) begin
          ref_mem[b_addr] = b_wdata; ref_valid[b_addr] = 1'b1;
        end else if (ref_valid[b_addr]) begin
          n_cmp++;
          if (b_rdata !== ref_mem[b_addr]) begin
            n_err++;
            $display("FAIL random_b_rdata[%h]: got %h required %h", b_addr, b_rdata, ref_mem[b_addr]);
          end
        end
        b_req = live && ($urandom_range(0, 1) == 1);
        b_we = 1'($urandom_range(0, 1)); b_addr = pool[$urandom_range(0, 15)]; b_wdata = 8'($urandom);
      end else if (!b_req && live && $urandom_range(0, 2) == 0) begin
        b_req = 1'b1;
        b_we = 1'($urandom_range(0, 1)); b_addr = pool[$urandom_range(0, 15)]; b_wdata = 8'($urandom);
      end
      if (pend != 0) pend = 0;
      else if (a_req && b_req) begin
        gb = RR ? !mdl_last_b : 1'b0;
        pend = gb ? 2 : 1; mdl_last_b = gb;
      end else if (a_req) begin
        pend = 1; mdl_last_b = 1'b0;
      end else if (b_req) begin
        pend = 2; mdl_last_b = 1'b1;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge CLOCK_50);
  endtask

  initial begin
    pool[0] = 12'h000;
    pool[1] = 12'hFFF;
    for (int i = 2; i < 16; i++) pool[i] = 12'($urandom_range(0, 4095));
    test_reset;
    test_write_read;
    test_b_fresh;
    test_back_to_back;
    test_contention;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
